ir_key_decoder: RTL

Downstream consumer of the NEC IR receiver's 32-bit frame output (`ir_data`/`ir_vld`). It bit-reverses and validates each frame (address and command complement checks, optional device-address filter) and suppresses duplicate presses inside a hold-off window. Accepted key codes go into a small show-ahead FIFO that the control logic (LED/segment display, UART) pops with a ready/valid-style read strobe.

---
 rtl/ir_key_decoder.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ir_key_decoder.sv
// NEC IR frame validator: bit-reverses and checks each 32-bit frame, filters by address,
// suppresses repeats inside a hold-off window and queues accepted keys in a show-ahead FIFO.
module ir_key_decoder #(
  parameter logic [7:0]  DEV_ADDR       = 8'h00,
  parameter bit          ADDR_FILTER_EN = 1'b1,
  parameter int unsigned HOLDOFF_CYC    = 20_000_000,
  parameter int unsigned FIFO_AW        = 2
) (
  input  logic        clk100M,
  input  logic        rst,
  input  logic [31:0] ir_data,
  input  logic        ir_vld,
  input  logic        clr_stat,
  input  logic        key_rd,
  output logic        key_vld,
  output logic [7:0]  key_addr,
  output logic [7:0]  key_code,
  output logic [7:0]  err_cnt,
  output logic        ovf
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;
  localparam int unsigned TW    = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;

  typedef enum logic [1:0] {IDLE, CHK, PUSH} state_t;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  state_t          state_q, state_d;
  logic [7:0]      addr_q, addr_n_q, cmd_q, cmd_n_q;
  logic [TW-1:0]   timer_q;
  logic            last_vld_q;
  logic [15:0]     last_key_q;
  logic            chk_err, chk_supp, chk_acc, push;

  logic [15:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d, cnt_left;
  logic               pop, full, wr_ok, ovf_set;
  logic [15:0]        wdata, head_d;

  assign wdata = {addr_q, cmd_q};

  always_ff @(posedge clk100M or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Frame checks in priority order: complement error, address filter, repeat suppression
  always_comb begin
    state_d  = state_q;
    chk_err  = 1'b0;
    chk_supp = 1'b0;
    chk_acc  = 1'b0;
    push     = 1'b0;
    case (state_q)
      IDLE: if (ir_vld) state_d = CHK;
      CHK: begin
        state_d = IDLE;
        if ((addr_n_q != ~addr_q) || (cmd_n_q != ~cmd_q)) begin
          chk_err = 1'b1;
        end else if (ADDR_FILTER_EN && (addr_q != DEV_ADDR)) begin
          chk_supp = 1'b0;
        end else if (last_vld_q && (last_key_q == wdata) && (timer_q != '0)) begin
          chk_supp = 1'b1;
        end else begin
          chk_acc = 1'b1;
          state_d = PUSH;
        end
      end
      PUSH: begin
        push    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk100M or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      addr_n_q <= '0;
      cmd_q    <= '0;
      cmd_n_q  <= '0;
    end else if ((state_q == IDLE) && ir_vld) begin
      addr_q   <= rev8(ir_data[31:24]);
      addr_n_q <= rev8(ir_data[23:16]);
      cmd_q    <= rev8(ir_data[15:8]);
      cmd_n_q  <= rev8(ir_data[7:0]);
    end
  end

  // Hold-off timer restarts on every accepted or suppressed repeat
  always_ff @(posedge clk100M or posedge rst) begin
    if (rst) begin
      timer_q    <= '0;
      last_vld_q <= 1'b0;
      last_key_q <= '0;
    end else begin
      if (chk_supp || chk_acc) timer_q <= TW'(HOLDOFF_CYC - 1);
      else if (timer_q != '0)  timer_q <= timer_q - TW'(1);
      if (chk_acc) begin
        last_vld_q <= 1'b1;
        last_key_q <= wdata;
      end
    end
  end

  always_ff @(posedge clk100M or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
      ovf     <= 1'b0;
    end else if (clr_stat) begin
      err_cnt <= '0;
      ovf     <= 1'b0;
    end else begin
      if (chk_err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
      if (ovf_set) ovf <= 1'b1;
    end
  end

  // Head of the next cycle: the incoming entry when nothing else remains queued
  always_comb begin
    pop      = key_rd && (count_q != '0);
    full     = (count_q == CW'(DEPTH));
    wr_ok    = push && (!full || pop);
    ovf_set  = push && full && !pop;
    cnt_left = count_q - CW'(pop);
    count_d  = cnt_left + CW'(wr_ok);
    rd_ptr_d = pop ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    head_d   = (cnt_left == '0) ? wdata : mem[rd_ptr_d];
  end

  always_ff @(posedge clk100M or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      key_vld  <= 1'b0;
      key_addr <= '0;
      key_code <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      key_vld  <= (count_d != '0);
      if (count_d != '0) {key_addr, key_code} <= head_d;
    end
  end

  always_ff @(posedge clk100M) begin
    if (wr_ok) mem[wr_ptr_q] <= wdata;
  end

endmodule
